// File: rtl/array_reduce_stream.sv
// array_reduce_stream
// Buffers a frame of ELEM_W-bit elements received over a valid/ready stream,
// then folds the stored elements one per cycle into sum, product, AND, OR and
// XOR results that are held on an output valid/ready handshake.
//
// Optional feature: define ARRAY_REDUCE_PRODUCT_EN to build the product
// accumulator and multiplier; otherwise out_product is constant 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_data, in_last      element value, end-of-frame marker
//   out_valid/out_ready   result handshake
//   out_sum/product/and/or/xor  reduction results (ELEM_W each)
//   out_count             stored element count (saturates at MAX_ELEMS)
//   out_overflow          frame carried more than MAX_ELEMS beats
module array_reduce_stream #(
  parameter int ELEM_W    = 32,
  parameter int MAX_ELEMS = 8,
  localparam int CNT_W    = $clog2(MAX_ELEMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_sum,
  output logic [ELEM_W-1:0] out_product,
  output logic [ELEM_W-1:0] out_and,
  output logic [ELEM_W-1:0] out_or,
  output logic [ELEM_W-1:0] out_xor,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  localparam int IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_ELEMS);

  typedef enum logic [1:0] {FILL, REDUCE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ELEM_W-1:0]  mem_q [MAX_ELEMS];
  logic               we;
  logic [CNT_W-1:0]   wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic               ovf_q, ovf_d, rovf_q, rovf_d;
  logic [ELEM_W-1:0]  elem;
  logic [ELEM_W-1:0]  acc_sum_q, acc_sum_d, acc_and_q, acc_and_d;
  logic [ELEM_W-1:0]  acc_or_q, acc_or_d, acc_xor_q, acc_xor_d;
  logic [ELEM_W-1:0]  res_sum_q, res_sum_d, res_and_q, res_and_d;
  logic [ELEM_W-1:0]  res_or_q, res_or_d, res_xor_q, res_xor_d;
`ifdef ARRAY_REDUCE_PRODUCT_EN
  logic [ELEM_W-1:0]  acc_prod_q, acc_prod_d, res_prod_q, res_prod_d;
`endif

  assign in_ready     = (state_q == FILL);
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = res_sum_q;
  assign out_and      = res_and_q;
  assign out_or       = res_or_q;
  assign out_xor      = res_xor_q;
  assign out_count    = cnt_q;
  assign out_overflow = rovf_q;
`ifdef ARRAY_REDUCE_PRODUCT_EN
  assign out_product  = res_prod_q;
`else
  assign out_product  = '0;
`endif

  assign elem = mem_q[rd_q[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    we        = 1'b0;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rovf_d    = rovf_q;
    acc_sum_d = acc_sum_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;
    acc_xor_d = acc_xor_q;
    res_sum_d = res_sum_q;
    res_and_d = res_and_q;
    res_or_d  = res_or_q;
    res_xor_d = res_xor_q;
`ifdef ARRAY_REDUCE_PRODUCT_EN
    acc_prod_d = acc_prod_q;
    res_prod_d = res_prod_q;
`endif
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (wr_q < MAX_CNT) begin
            we   = 1'b1;
            wr_d = wr_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d   = REDUCE;
            rd_d      = '0;
            acc_sum_d = '0;
            acc_and_d = '1;
            acc_or_d  = '0;
            acc_xor_d = '0;
`ifdef ARRAY_REDUCE_PRODUCT_EN
            acc_prod_d = ELEM_W'(1);
`endif
          end
        end
      end
      REDUCE: begin
        acc_sum_d = acc_sum_q + elem;
        acc_and_d = acc_and_q & elem;
        acc_or_d  = acc_or_q | elem;
        acc_xor_d = acc_xor_q ^ elem;
`ifdef ARRAY_REDUCE_PRODUCT_EN
        acc_prod_d = acc_prod_q * elem;
`endif
        rd_d = rd_q + ONE;
        // wr_q already saturated at MAX_ELEMS, so it is the frame count here.
        // Results are captured from the fold values so out_* update exactly
        // at the final fold edge and stay untouched during later frames.
        if (rd_q == wr_q - ONE) begin
          state_d   = HOLD;
          cnt_d     = wr_q;
          rovf_d    = ovf_q;
          res_sum_d = acc_sum_d;
          res_and_d = acc_and_d;
          res_or_d  = acc_or_d;
          res_xor_d = acc_xor_d;
`ifdef ARRAY_REDUCE_PRODUCT_EN
          res_prod_d = acc_prod_d;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          wr_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q[IDX_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rovf_q    <= 1'b0;
      acc_sum_q <= '0;
      acc_and_q <= '0;
      acc_or_q  <= '0;
      acc_xor_q <= '0;
      res_sum_q <= '0;
      res_and_q <= '0;
      res_or_q  <= '0;
      res_xor_q <= '0;
`ifdef ARRAY_REDUCE_PRODUCT_EN
      acc_prod_q <= '0;
      res_prod_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rovf_q    <= rovf_d;
      acc_sum_q <= acc_sum_d;
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
      acc_xor_q <= acc_xor_d;
      res_sum_q <= res_sum_d;
      res_and_q <= res_and_d;
      res_or_q  <= res_or_d;
      res_xor_q <= res_xor_d;
`ifdef ARRAY_REDUCE_PRODUCT_EN
      acc_prod_q <= acc_prod_d;
      res_prod_q <= res_prod_d;
`endif
    end
  end

endmodule

// File: tb/tb_array_reduce_stream.sv
// Directed self-checking bench for array_reduce_stream (MAX_ELEMS = 8).
module tb_array_reduce_stream;

  localparam int ELEM_W    = 32;
  localparam int MAX_ELEMS = 8;
  localparam int CNT_W     = $clog2(MAX_ELEMS + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_last;
  logic [ELEM_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [ELEM_W-1:0] out_sum, out_product, out_and, out_or, out_xor;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  int tests = 0;
  int fails = 0;

  array_reduce_stream #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAX_ELEMS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_product(out_product), .out_and(out_and),
    .out_or(out_or), .out_xor(out_xor),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xprod(input logic [31:0] p);
`ifdef ARRAY_REDUCE_PRODUCT_EN
    return p;
`else
    return 32'h0 & p;
`endif
  endfunction

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  // Cycles from last-beat acceptance to out_valid, bounded.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic check_results(input string tag, input logic [31:0] s, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] o, input logic [31:0] x,
                               input int c, input logic ov);
    check({tag, ".valid"}, 64'(out_valid), 64'(1));
    check({tag, ".sum"},   64'(out_sum), 64'(s));
    check({tag, ".prod"},  64'(out_product), 64'(xprod(p)));
    check({tag, ".and"},   64'(out_and), 64'(a));
    check({tag, ".or"},    64'(out_or), 64'(o));
    check({tag, ".xor"},   64'(out_xor), 64'(x));
    check({tag, ".count"}, 64'(out_count), 64'(c));
    check({tag, ".ovf"},   64'(out_overflow), 64'(ov));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_after"}, 64'(out_valid), 64'(0));
    check({tag, ".ready_after"}, 64'(in_ready), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    check({tag, ".valid"},    64'(out_valid), 64'(0));
    check({tag, ".sum"},      64'(out_sum), 64'(0));
    check({tag, ".prod"},     64'(out_product), 64'(0));
    check({tag, ".and"},      64'(out_and), 64'(0));
    check({tag, ".or"},       64'(out_or), 64'(0));
    check({tag, ".xor"},      64'(out_xor), 64'(0));
    check({tag, ".count"},    64'(out_count), 64'(0));
    check({tag, ".ovf"},      64'(out_overflow), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1..5
    for (int i = 1; i <= 5; i++) send(32'(i), i == 5);
    check("f5.ready_low", 64'(in_ready), 64'(0));
    wait_valid("f5.latency", 5);
    check_results("f5", 32'd15, 32'd120, 32'd0, 32'd7, 32'd1, 5, 1'b0);
    consume("f5");

    // Single all-ones beat
    send(32'hFFFF_FFFF, 1'b1);
    wait_valid("f1.latency", 1);
    check_results("f1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    consume("f1");

    // Ten beats of 1: overflow, count saturates at 8
    for (int i = 1; i <= 10; i++) send(32'd1, i == 10);
    wait_valid("ovf.latency", 8);
    check_results("ovf", 32'd8, 32'd1, 32'd1, 32'd1, 32'd0, 8, 1'b1);
    consume("ovf");

    // Wrap frame, then backpressure in HOLD with junk on the input side
    send(32'h8000_0000, 1'b0);
    send(32'h8000_0000, 1'b1);
    wait_valid("wrap.latency", 2);
    check_results("wrap", 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 2, 1'b0);
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.valid", 64'(out_valid), 64'(1));
      check("bp.in_ready", 64'(in_ready), 64'(0));
      check("bp.or", 64'(out_or), 64'(32'h8000_0000));
      check("bp.count", 64'(out_count), 64'(2));
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume("bp");
    check("bp.or_kept", 64'(out_or), 64'(32'h8000_0000));
    check("bp.and_kept", 64'(out_and), 64'(32'h8000_0000));

    // Reset during REDUCE of a 6-element frame
    for (int i = 1; i <= 6; i++) send(32'(i * 3), i == 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid.in_reduce", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mid_post");

    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    wait_valid("f23.latency", 2);
    check_results("f23", 32'd5, 32'd6, 32'd2, 32'd3, 32'd1, 2, 1'b0);
    consume("f23");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
